debug_control: RTL and testbench
================================

# debug_control

Run-control state machine for the core's Debug Mode. It takes halt and resume requests from the Debug Module and `ebreak`/step events from the retire stage. It drains the core, then produces the `debug` mode flag consumed by the CSR file, plus the `dpc` and `dcsr.cause` write strobes. On resume it redirects fetch to `dpc` and, when `dcsr.step` is set, re-halts after exactly one retired instruction.

## Interface
- `XLEN`, 32, datapath and PC width
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `halt_req`  in  1  Debug Module halt request, level
- `resume_req`  in  1  Debug Module resume request, level
- `retire_valid`  in  1  one instruction retires this cycle
- `retire_pc`  in  XLEN  PC of the retiring instruction
- `retire_next_pc`  in  XLEN  PC of the instruction following it
- `retire_ebreak`  in  1  the retiring instruction is `ebreak`
- `core_idle`  in  1  pipeline empty, nothing in flight
- `dcsr_ebreakm`  in  1  `dcsr.ebreakm` from the CSR file
- `dcsr_step`  in  1  `dcsr.step` from the CSR file
- `dpc`  in  XLEN  current `dpc` from the CSR file
- `debug`  out  1  core in Debug Mode; drives the CSR file `debug` input
- `halted`  out  1  status to the Debug Module
- `resume_ack`  out  1  one-cycle pulse when a resume is performed
- `stall`  out  1  stop fetch/issue
- `dpc_we`  out  1  write strobe for `dpc`
- `dpc_wdata`  out  XLEN  value to write into `dpc`
- `cause_we`  out  1  write strobe for `dcsr.cause`
- `cause`  out  3  value to write into `dcsr.cause`
- `redirect`  out  1  fetch redirect pulse
- `redirect_pc`  out  XLEN  redirect target, equal to `dpc`

## Operation
- **States:** RUN, DRAIN, HALTED, RESUME, STEP.
- **Cause encoding:** ebreak=1, haltreq=3, step=4, resethaltreq=5.
- **Cause priority when several apply in one cycle:** ebreak > resethaltreq > haltreq > step.
- **`next_pc_q`:** updated to `retire_next_pc` on every `retire_valid`.

**RUN**
- `retire_valid && retire_ebreak && dcsr_ebreakm` goes to DRAIN.
  - Cause is 1.
  - Captured PC is `retire_pc`. The `ebreak` itself is re-executed on resume.
- Otherwise, `halt_req` goes to DRAIN.
  - Cause is 3.
  - Captured PC is `next_pc_q`, taken at drain completion.
- **First cycle after reset:** `halt_req`=1 gives cause 5 instead of 3.

**DRAIN**
- `stall`=1.
- Retirements still update `next_pc_q`.
- When `core_idle`=1:
  - assert `dpc_we` and `cause_we` that same cycle (combinational);
  - drive `dpc_wdata` from the captured PC;
  - go to HALTED.

**HALTED**
- `debug`=1, `halted`=1, `stall`=1.
- `resume_req && !halt_req` goes to RESUME.
- A resume request while `halt_req` is also high is ignored.

**RESUME**
- Lasts one cycle: `redirect`=1, `redirect_pc`=`dpc`, `resume_ack`=1, `stall`=0.
- `debug` is still 1 in this cycle.
- Next state is STEP if `dcsr_step`, else RUN.

**STEP**
- `debug`=0; fetch runs.
- On the first `retire_valid`, go to DRAIN with cause 4 and captured PC `retire_next_pc`.
  - `stall` rises in the same cycle.
  - Exactly one instruction retires.
- A retiring `ebreak` with `dcsr_ebreakm` overrides with cause 1 and PC `retire_pc`.
- `halt_req` before any retire gives cause 3 and behaves as in RUN.

**Reset**
- `rst_n` low at any point, including mid-DRAIN or mid-STEP, forces RUN.
- Reset values: all outputs 0, `next_pc_q`=0.
- Pending cause and captured PC are discarded.

## Timing
- State and `next_pc_q` are registered. Outputs are decoded from state, except `dpc_we`/`cause_we`/`dpc_wdata`, which are qualified by `core_idle` in DRAIN.
- **Halt latency** (`halt_req` seen in RUN, core already idle):
  - cycle 1: DRAIN, with strobes;
  - cycle 2: HALTED, `debug`=1.
- **Resume latency:** `resume_req` in HALTED gives RESUME the next cycle, then RUN/STEP the cycle after.
- `resume_ack` is high in exactly one cycle per resume. The Debug Module must drop `resume_req` after it; a still-high `resume_req` on a later halt causes a new resume.
- `halt_req` held high across a resume re-halts immediately after RESUME. This is legal and counts as a new halt.
- `dcsr_step` is sampled only in RESUME.
- Simultaneous `halt_req` and retiring `ebreak` in RUN: cause 1.

## Structure
- **Shared header** (alongside the CSR header):
  - `DEBUG__CAUSE_*` constants;
  - the state typedef (3-bit enum);
  - `DEBUG__CAUSE_WIDTH`=3.
- **Sub-module `debug_cause_select`:** combinational priority encoder taking the event flags and producing cause plus captured-PC select. Everything else is one FSM module.

## Test plan
- **Basic halt:** RUN with `core_idle`=1, `next_pc_q`=0x100, pulse `halt_req` -> `dpc_we` with 0x100, `cause`=3; `debug`=`halted`=1 two cycles after the request.
- **Ebreak:** retire `ebreak` at 0x200 with `dcsr_ebreakm`=1, `core_idle` late by 3 cycles -> `stall` held for 3 cycles, `dpc_wdata`=0x200, `cause`=1.
- **Plain resume:** HALTED, `dpc`=0x300, `resume_req` -> one-cycle `redirect` to 0x300 with `resume_ack`, then RUN with `debug`=0.
- **Single step:** `dcsr_step`=1, resume, retire one instruction (`next_pc`=0x304) -> re-halt with `cause`=4, `dpc`=0x304, exactly one `retire_valid` accepted.
- **Reset halt:** `halt_req`=1 during and after reset -> `cause`=5.
- **Resume blocked:** `halt_req` and `resume_req` both high in HALTED -> no `resume_ack`.
- **Reset mid-drain:** `rst_n` low mid-DRAIN -> all outputs 0 and state RUN next cycle.

Source files
------------

// File: rtl/debug_control_pkg.sv
// Shared debug run-control definitions: dcsr.cause codes, FSM state encoding
// and the captured-PC source select.
package debug_control_pkg;

  localparam int unsigned DEBUG__CAUSE_WIDTH = 3;

  typedef logic [DEBUG__CAUSE_WIDTH-1:0] debug_cause_t;

  localparam debug_cause_t DEBUG__CAUSE_NONE         = 3'd0;
  localparam debug_cause_t DEBUG__CAUSE_EBREAK       = 3'd1;
  localparam debug_cause_t DEBUG__CAUSE_HALTREQ      = 3'd3;
  localparam debug_cause_t DEBUG__CAUSE_STEP         = 3'd4;
  localparam debug_cause_t DEBUG__CAUSE_RESETHALTREQ = 3'd5;

  // 3-bit state encoding, kept as plain constants for older tools.
  typedef logic [2:0] debug_state_t;

  localparam debug_state_t DEBUG__ST_RUN    = 3'd0;
  localparam debug_state_t DEBUG__ST_DRAIN  = 3'd1;
  localparam debug_state_t DEBUG__ST_HALTED = 3'd2;
  localparam debug_state_t DEBUG__ST_RESUME = 3'd3;
  localparam debug_state_t DEBUG__ST_STEP   = 3'd4;

  // Where the PC written to dpc comes from.
  //   PcSelLive       : next_pc_q sampled when the drain completes
  //   PcSelRetire     : retire_pc captured at the event
  //   PcSelRetireNext : retire_next_pc captured at the event
  typedef enum logic [1:0] {
    PcSelLive,
    PcSelRetire,
    PcSelRetireNext
  } debug_pc_sel_e;

  // True while the core is architecturally in Debug Mode.
  function automatic logic debug_state_in_mode(debug_state_t st);
    return (st == DEBUG__ST_HALTED) || (st == DEBUG__ST_RESUME);
  endfunction

endpackage

// File: rtl/debug_control_if.sv
// Signals between debug_control, the retire stage, the CSR file and the
// Debug Module. The slave side is debug_control itself.
interface debug_control_if #(
  parameter int unsigned XLEN = 32
);

  // Debug Module requests
  logic            halt_req;
  logic            resume_req;
  // Retire stage
  logic            retire_valid;
  logic [XLEN-1:0] retire_pc;
  logic [XLEN-1:0] retire_next_pc;
  logic            retire_ebreak;
  logic            core_idle;
  // CSR file
  logic            dcsr_ebreakm;
  logic            dcsr_step;
  logic [XLEN-1:0] dpc;

  // Run-control outputs
  logic            debug;
  logic            halted;
  logic            resume_ack;
  logic            stall;
  logic            dpc_we;
  logic [XLEN-1:0] dpc_wdata;
  logic            cause_we;
  logic [2:0]      cause;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;

  modport master (
    output halt_req, resume_req, retire_valid, retire_pc, retire_next_pc, retire_ebreak,
           core_idle, dcsr_ebreakm, dcsr_step, dpc,
    input  debug, halted, resume_ack, stall, dpc_we, dpc_wdata, cause_we, cause,
           redirect, redirect_pc
  );

  modport slave (
    input  halt_req, resume_req, retire_valid, retire_pc, retire_next_pc, retire_ebreak,
           core_idle, dcsr_ebreakm, dcsr_step, dpc,
    output debug, halted, resume_ack, stall, dpc_we, dpc_wdata, cause_we, cause,
           redirect, redirect_pc
  );

endinterface

// File: rtl/debug_cause_select.sv
// Priority encoder for debug entry events. Picks the dcsr.cause value and the
// source of the PC that will later be written to dpc.
module debug_cause_select
  import debug_control_pkg::*;
(
  input  logic          ebreak_evt,
  input  logic          reset_halt_evt,
  input  logic          halt_evt,
  input  logic          step_evt,
  output logic          evt_valid,
  output debug_cause_t  cause,
  output debug_pc_sel_e pc_sel
);

  // ebreak > resethaltreq > haltreq > step
  always_comb begin
    evt_valid = 1'b1;
    cause     = DEBUG__CAUSE_NONE;
    pc_sel    = PcSelLive;
    if (ebreak_evt) begin
      // The ebreak itself is re-executed on resume.
      cause  = DEBUG__CAUSE_EBREAK;
      pc_sel = PcSelRetire;
    end else if (reset_halt_evt) begin
      cause  = DEBUG__CAUSE_RESETHALTREQ;
      pc_sel = PcSelLive;
    end else if (halt_evt) begin
      cause  = DEBUG__CAUSE_HALTREQ;
      pc_sel = PcSelLive;
    end else if (step_evt) begin
      cause  = DEBUG__CAUSE_STEP;
      pc_sel = PcSelRetireNext;
    end else begin
      evt_valid = 1'b0;
    end
  end

endmodule

// File: rtl/debug_control.sv
// Debug Mode run-control FSM: drains the core on halt/ebreak/step events,
// writes dpc and dcsr.cause, holds the core halted and performs resumes.
module debug_control
  import debug_control_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input logic         clk,
  input logic         rst_n,
  debug_control_if.slave bus
);

  debug_state_t  state_q, state_d;
  logic [XLEN-1:0] next_pc_q;
  logic            first_q;
  debug_cause_t    cause_q;
  debug_pc_sel_e   pc_sel_q;
  logic [XLEN-1:0] cap_pc_q;

  logic          in_run;
  logic          in_step;
  logic          in_drain;
  logic          ebreak_hit;
  logic          drain_done;
  logic          evt_valid;
  debug_cause_t  sel_cause;
  debug_pc_sel_e sel_pc;

  assign in_run     = (state_q == DEBUG__ST_RUN);
  assign in_step    = (state_q == DEBUG__ST_STEP);
  assign in_drain   = (state_q == DEBUG__ST_DRAIN);
  assign ebreak_hit = bus.retire_valid & bus.retire_ebreak & bus.dcsr_ebreakm;
  assign drain_done = in_drain & bus.core_idle;

  // Entry events are only meaningful while the core is executing (RUN/STEP);
  // the reset-halt variant exists only in the first cycle after reset.
  debug_cause_select u_cause_select (
    .ebreak_evt     ((in_run | in_step) & ebreak_hit),
    .reset_halt_evt (in_run & first_q & bus.halt_req),
    .halt_evt       ((in_run | in_step) & bus.halt_req),
    .step_evt       (in_step & bus.retire_valid),
    .evt_valid      (evt_valid),
    .cause          (sel_cause),
    .pc_sel         (sel_pc)
  );

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      DEBUG__ST_RUN,
      DEBUG__ST_STEP: begin
        if (evt_valid) state_d = DEBUG__ST_DRAIN;
      end
      DEBUG__ST_DRAIN: begin
        if (bus.core_idle) state_d = DEBUG__ST_HALTED;
      end
      DEBUG__ST_HALTED: begin
        // A resume while halt_req is still asserted is ignored.
        if (bus.resume_req && !bus.halt_req) state_d = DEBUG__ST_RESUME;
      end
      DEBUG__ST_RESUME: begin
        // dcsr.step only matters here.
        state_d = bus.dcsr_step ? DEBUG__ST_STEP : DEBUG__ST_RUN;
      end
      default: state_d = DEBUG__ST_RUN;
    endcase
  end

  // State, architectural next PC and the pending cause/PC of a debug entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= DEBUG__ST_RUN;
      next_pc_q <= '0;
      first_q   <= 1'b1;
      cause_q   <= DEBUG__CAUSE_NONE;
      pc_sel_q  <= PcSelLive;
      cap_pc_q  <= '0;
    end else begin
      state_q <= state_d;
      first_q <= 1'b0;
      if (bus.retire_valid) begin
        next_pc_q <= bus.retire_next_pc;
      end
      if (evt_valid) begin
        cause_q  <= sel_cause;
        pc_sel_q <= sel_pc;
        cap_pc_q <= (sel_pc == PcSelRetire) ? bus.retire_pc : bus.retire_next_pc;
      end
    end
  end

  // Outputs are decoded from state; the CSR write strobes are also
  // qualified by core_idle so they fire in the cycle the drain completes.
  always_comb begin
    bus.debug       = debug_state_in_mode(state_q);
    bus.halted      = (state_q == DEBUG__ST_HALTED);
    bus.resume_ack  = (state_q == DEBUG__ST_RESUME);
    bus.redirect    = (state_q == DEBUG__ST_RESUME);
    bus.redirect_pc = (state_q == DEBUG__ST_RESUME) ? bus.dpc : '0;
    // In STEP, stall rises with the single retirement so no second
    // instruction slips through before DRAIN is entered.
    bus.stall       = in_drain | (state_q == DEBUG__ST_HALTED) | (in_step & bus.retire_valid);
    bus.dpc_we      = drain_done;
    bus.cause_we    = drain_done;
    bus.cause       = drain_done ? cause_q : DEBUG__CAUSE_NONE;
    bus.dpc_wdata   = '0;
    if (drain_done) begin
      bus.dpc_wdata = (pc_sel_q == PcSelLive) ? next_pc_q : cap_pc_q;
    end
  end

endmodule

// File: tb/tb_debug_control.sv
// Directed and randomized bench for debug_control.
module tb_debug_control;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  debug_control_if #(.XLEN(32)) bus ();

  debug_control #(.XLEN(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs are changed 1 time unit after the rising edge; outputs are
  // sampled 1 more unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs(input logic idle);
    bus.halt_req       = 1'b0;
    bus.resume_req     = 1'b0;
    bus.retire_valid   = 1'b0;
    bus.retire_ebreak  = 1'b0;
    bus.retire_pc      = 32'h0;
    bus.retire_next_pc = 32'h0;
    bus.core_idle      = idle;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_debug"},    {31'b0, bus.debug},      32'h0);
    chk({tag, "_halted"},   {31'b0, bus.halted},     32'h0);
    chk({tag, "_stall"},    {31'b0, bus.stall},      32'h0);
    chk({tag, "_dpc_we"},   {31'b0, bus.dpc_we},     32'h0);
    chk({tag, "_cause_we"}, {31'b0, bus.cause_we},   32'h0);
    chk({tag, "_redirect"}, {31'b0, bus.redirect},   32'h0);
    chk({tag, "_ack"},      {31'b0, bus.resume_ack}, 32'h0);
  endtask

  task automatic chk_strobe(input string tag, input logic [2:0] c, input logic [31:0] pc);
    chk({tag, "_dpc_we"},   {31'b0, bus.dpc_we},   32'h1);
    chk({tag, "_cause_we"}, {31'b0, bus.cause_we}, 32'h1);
    chk({tag, "_cause"},    {29'b0, bus.cause},    {29'b0, c});
    chk({tag, "_dpc_wdata"}, bus.dpc_wdata,        pc);
  endtask

  // Reference model state: the PC after the most recent retirement.
  logic [31:0] model_next_pc;
  logic [31:0] exp_pc;
  logic [2:0]  exp_cause;
  logic [31:0] rpc;
  logic [31:0] rdpc;
  logic        do_step;
  logic        is_halt;
  logic        is_ebreak;
  int unsigned k;

  // Random ordinary retirement; the model tracks the architectural next PC.
  task automatic rand_retire();
    logic [31:0] p;
    bus.retire_ebreak = 1'b0;
    bus.retire_valid  = 1'($urandom_range(0, 1));
    if (bus.retire_valid) begin
      p = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
      bus.retire_pc      = p;
      bus.retire_next_pc = $urandom_range(0, 1) ? p + 32'd4 : {$urandom, 2'b00} >> 2 << 2;
      model_next_pc      = bus.retire_next_pc;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_next_pc = 32'h0;
    rst_n = 1'b0;
    idle_inputs(1'b1);
    bus.dcsr_ebreakm = 1'b0;
    bus.dcsr_step    = 1'b0;
    bus.dpc          = 32'h0;

    // ---------------- reset state ----------------
    tick();
    tick();
    settle();
    chk_quiet("reset");
    rst_n = 1'b1;

    // ---------------- basic halt ----------------
    bus.retire_valid = 1'b1;
    bus.retire_pc = 32'hfc;
    bus.retire_next_pc = 32'h100;
    tick();
    idle_inputs(1'b1);
    bus.halt_req = 1'b1;
    settle();
    chk("halt_req_cycle_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    bus.halt_req = 1'b0;
    settle();
    chk_strobe("halt", 3'd3, 32'h100);
    chk("halt_drain_stall", {31'b0, bus.stall}, 32'h1);
    chk("halt_drain_debug", {31'b0, bus.debug}, 32'h0);
    tick();
    settle();
    chk("halt_debug", {31'b0, bus.debug}, 32'h1);
    chk("halt_halted", {31'b0, bus.halted}, 32'h1);

    // ---------------- plain resume ----------------
    bus.dpc = 32'h300;
    bus.resume_req = 1'b1;
    settle();
    chk("resume_req_no_ack_yet", {31'b0, bus.resume_ack}, 32'h0);
    tick();
    bus.resume_req = 1'b0;
    settle();
    chk("resume_redirect", {31'b0, bus.redirect}, 32'h1);
    chk("resume_redirect_pc", bus.redirect_pc, 32'h300);
    chk("resume_ack", {31'b0, bus.resume_ack}, 32'h1);
    chk("resume_debug", {31'b0, bus.debug}, 32'h1);
    chk("resume_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    settle();
    chk_quiet("after_resume");

    // ---------------- ebreak with late core_idle ----------------
    bus.retire_valid = 1'b1;
    bus.retire_ebreak = 1'b1;
    bus.retire_pc = 32'h200;
    bus.retire_next_pc = 32'h204;
    bus.dcsr_ebreakm = 1'b1;
    bus.core_idle = 1'b0;
    tick();
    idle_inputs(1'b0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("ebreak_drain_stall", {31'b0, bus.stall}, 32'h1);
      chk("ebreak_drain_no_we", {31'b0, bus.dpc_we}, 32'h0);
      tick();
    end
    bus.core_idle = 1'b1;
    settle();
    chk_strobe("ebreak", 3'd1, 32'h200);
    tick();
    settle();
    chk("ebreak_halted", {31'b0, bus.halted}, 32'h1);

    // ---------------- single step ----------------
    bus.dcsr_step = 1'b1;
    bus.dpc = 32'h300;
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    settle();
    chk("step_resume_ack", {31'b0, bus.resume_ack}, 32'h1);
    tick();
    bus.dcsr_step = 1'b0;
    settle();
    chk("step_debug_low", {31'b0, bus.debug}, 32'h0);
    chk("step_no_stall", {31'b0, bus.stall}, 32'h0);
    tick();
    bus.retire_valid = 1'b1;
    bus.retire_ebreak = 1'b0;
    bus.retire_pc = 32'h300;
    bus.retire_next_pc = 32'h304;
    settle();
    chk("step_retire_stall", {31'b0, bus.stall}, 32'h1);
    tick();
    idle_inputs(1'b1);
    settle();
    chk_strobe("step", 3'd4, 32'h304);
    tick();
    settle();
    chk("step_rehalted", {31'b0, bus.halted}, 32'h1);

    // ---------------- resume blocked by halt_req ----------------
    bus.halt_req = 1'b1;
    bus.resume_req = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      chk("blocked_no_ack", {31'b0, bus.resume_ack}, 32'h0);
      chk("blocked_halted", {31'b0, bus.halted}, 32'h1);
    end
    bus.halt_req = 1'b0;
    tick();
    bus.resume_req = 1'b0;
    settle();
    chk("unblocked_ack", {31'b0, bus.resume_ack}, 32'h1);
    tick();
    settle();
    chk_quiet("unblocked_run");

    // ---------------- reset mid-drain, then reset halt ----------------
    bus.halt_req = 1'b1;
    bus.core_idle = 1'b0;
    tick();
    settle();
    chk("pre_reset_drain_stall", {31'b0, bus.stall}, 32'h1);
    rst_n = 1'b0;
    tick();
    settle();
    chk_quiet("mid_drain_reset");
    model_next_pc = 32'h0;
    rst_n = 1'b1;
    bus.core_idle = 1'b1;
    tick();
    bus.halt_req = 1'b0;
    settle();
    chk_strobe("reset_halt", 3'd5, 32'h0);
    tick();
    bus.resume_req = 1'b1;
    tick();
    bus.resume_req = 1'b0;
    tick();
    settle();
    chk_quiet("post_reset_halt_run");

    // ---------------- randomized scenarios against the model ----------------
    bus.dcsr_step = 1'b0;
    for (int s = 0; s < 40; s++) begin
      k = $urandom_range(0, 3);
      for (int i = 0; i < int'(k); i++) begin
        idle_inputs(1'($urandom_range(0, 1)));
        rand_retire();
        settle();
        chk("rnd_run_stall", {31'b0, bus.stall}, 32'h0);
        chk("rnd_run_debug", {31'b0, bus.debug}, 32'h0);
        tick();
      end

      // Debug entry: either a halt request or an enabled ebreak (which wins
      // over a simultaneous halt request).
      is_halt = 1'($urandom_range(0, 1));
      idle_inputs(1'($urandom_range(0, 1)));
      if (is_halt) begin
        bus.halt_req = 1'b1;
        rand_retire();
        exp_cause = 3'd3;
      end else begin
        rpc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        bus.retire_valid   = 1'b1;
        bus.retire_ebreak  = 1'b1;
        bus.dcsr_ebreakm   = 1'b1;
        bus.retire_pc      = rpc;
        bus.retire_next_pc = rpc + 32'd4;
        bus.halt_req       = 1'($urandom_range(0, 1));
        model_next_pc      = rpc + 32'd4;
        exp_cause = 3'd1;
        exp_pc    = rpc;
      end
      tick();

      k = $urandom_range(0, 3);
      for (int i = 0; i < int'(k); i++) begin
        idle_inputs(1'b0);
        rand_retire();
        settle();
        chk("rnd_drain_stall", {31'b0, bus.stall}, 32'h1);
        chk("rnd_drain_no_we", {31'b0, bus.dpc_we}, 32'h0);
        tick();
      end
      idle_inputs(1'b1);
      if (is_halt) exp_pc = model_next_pc;
      settle();
      chk_strobe("rnd_entry", exp_cause, exp_pc);
      tick();
      settle();
      chk("rnd_halted", {31'b0, bus.halted}, 32'h1);
      chk("rnd_halted_debug", {31'b0, bus.debug}, 32'h1);

      if ($urandom_range(0, 1) == 1) begin
        bus.halt_req = 1'b1;
        bus.resume_req = 1'b1;
        tick();
        settle();
        chk("rnd_blocked_no_ack", {31'b0, bus.resume_ack}, 32'h0);
      end

      do_step = 1'($urandom_range(0, 1));
      rdpc = {$urandom, 2'b00} >> 2 << 2;
      bus.halt_req   = 1'b0;
      bus.resume_req = 1'b1;
      bus.dpc        = rdpc;
      bus.dcsr_step  = do_step;
      tick();
      bus.resume_req = 1'b0;
      settle();
      chk("rnd_resume_ack", {31'b0, bus.resume_ack}, 32'h1);
      chk("rnd_redirect_pc", bus.redirect_pc, rdpc);
      tick();
      bus.dcsr_step = 1'b0;

      if (do_step) begin
        k = $urandom_range(0, 2);
        for (int i = 0; i < int'(k); i++) begin
          settle();
          chk("rnd_step_wait_debug", {31'b0, bus.debug}, 32'h0);
          chk("rnd_step_wait_stall", {31'b0, bus.stall}, 32'h0);
          tick();
        end
        is_ebreak = 1'($urandom_range(0, 1));
        rpc = {$urandom_range(0, 32'h3fff_ffff), 2'b00};
        bus.retire_valid   = 1'b1;
        bus.retire_ebreak  = is_ebreak;
        bus.dcsr_ebreakm   = 1'b1;
        bus.retire_pc      = rpc;
        bus.retire_next_pc = rpc + 32'd8;
        model_next_pc      = rpc + 32'd8;
        exp_cause = is_ebreak ? 3'd1 : 3'd4;
        exp_pc    = is_ebreak ? rpc : rpc + 32'd8;
        settle();
        chk("rnd_step_stall", {31'b0, bus.stall}, 32'h1);
        tick();
        idle_inputs(1'b1);
        settle();
        chk_strobe("rnd_step", exp_cause, exp_pc);
        tick();
        bus.resume_req = 1'b1;
        tick();
        bus.resume_req = 1'b0;
        settle();
        chk("rnd_step_resume_ack", {31'b0, bus.resume_ack}, 32'h1);
        tick();
      end
      settle();
      chk("rnd_back_in_run", {31'b0, bus.debug}, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
